// File: rtl/dmem_bus_if_pkg.sv
// Shared encodings, widths and helpers for the data-memory bus interface.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_bus_if_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 8;

  localparam logic [DATA_W-1:0] ZERO_WORD     = '0;
  localparam logic              WRITE_ENABLE  = 1'b1;
  localparam logic              WRITE_DISABLE = 1'b0;
  localparam logic              CHIP_ENABLE   = 1'b1;
  localparam logic              CHIP_DISABLE  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Stores return nothing to the pipeline; loads pass the bus word through.
  function automatic logic [DATA_W-1:0] load_data(input logic we,
                                                  input logic [DATA_W-1:0] data);
    return (we == WRITE_ENABLE) ? ZERO_WORD : data;
  endfunction

endpackage

// File: rtl/dmem_bus_if.sv
// Bridges the mem-stage load/store request onto a cyc/stb/ack bus with timeout abort.
// Latency: request cycle N, bus strobe N+1, result returned combinationally on the ack cycle.
// Backpressure: stallreq_o holds the pipeline until ack/timeout/flush; stall_i parks the result in HOLD.
module dmem_bus_if
  import dmem_bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  output logic              stallreq_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  // Counter value on the last BUSY cycle allowed before abort.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   tmo_cnt;
  logic [DATA_W-1:0]  rd_buf;
  logic               launch;
  logic               ack_take;
  logic               timeout;
  logic               bus_end;

  // Next state, pipeline-facing outputs and the per-cycle event strobes.
  always_comb begin
    state_nxt  = state;
    stallreq_o = 1'b0;
    cpu_data_o = ZERO_WORD;
    launch     = 1'b0;
    ack_take   = 1'b0;
    timeout    = 1'b0;
    bus_end    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (cpu_ce_i == CHIP_ENABLE && !flush_i) begin
            launch     = 1'b1;
            stallreq_o = 1'b1;
            state_nxt  = BUSY;
          end
        end
        BUSY: begin
          // Flush beats ack, ack beats timeout.
          if (flush_i) begin
            bus_end   = 1'b1;
            state_nxt = IDLE;
          end else if (bus_ack_i) begin
            ack_take   = 1'b1;
            bus_end    = 1'b1;
            cpu_data_o = load_data(bus_we_o, bus_data_i);
            state_nxt  = stall_i ? HOLD : IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout   = 1'b1;
            bus_end   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stallreq_o = 1'b1;
          end
        end
        HOLD: begin
          cpu_data_o = rd_buf;
          if (flush_i || !stall_i) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Registered bus request fields: loaded on launch, cleared when the cycle ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_cyc_o  <= 1'b0;
      bus_stb_o  <= 1'b0;
      bus_we_o   <= WRITE_DISABLE;
      bus_sel_o  <= '0;
      bus_addr_o <= '0;
      bus_data_o <= ZERO_WORD;
    end else if (launch) begin
      bus_cyc_o  <= 1'b1;
      bus_stb_o  <= 1'b1;
      bus_we_o   <= cpu_we_i;
      bus_sel_o  <= cpu_sel_i;
      bus_addr_o <= cpu_addr_i;
      bus_data_o <= cpu_data_i;
    end else if (bus_end) begin
      bus_cyc_o  <= 1'b0;
      bus_stb_o  <= 1'b0;
      bus_we_o   <= WRITE_DISABLE;
      bus_sel_o  <= '0;
      bus_addr_o <= '0;
      bus_data_o <= ZERO_WORD;
    end
  end

  // Timeout counter: restarts on launch, counts every BUSY cycle that does not finish.
  always_ff @(posedge clk) begin
    if (rst)                              tmo_cnt <= '0;
    else if (launch)                      tmo_cnt <= '0;
    else if (state == BUSY && !bus_end)   tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  // Read buffer captures the bus word on ack so HOLD can replay it.
  always_ff @(posedge clk) begin
    if (rst)           rd_buf <= ZERO_WORD;
    else if (ack_take) rd_buf <= bus_data_i;
  end

  // Abort error: single-cycle pulse following the timeout cycle.
  always_ff @(posedge clk) begin
    if (rst) bus_err_o <= 1'b0;
    else     bus_err_o <= timeout;
  end

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed bench for dmem_bus_if with a short timeout.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: stall_i/flush_i exercised explicitly per scenario.
module tb_dmem_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i, cpu_we_i, stall_i, flush_i, bus_ack_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_addr_i, cpu_data_i, bus_data_i;
  logic [31:0] cpu_data_o, bus_addr_o, bus_data_o;
  logic        stallreq_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o;
  logic [3:0]  bus_sel_o;

  int n_vec = 0;
  int n_err = 0;

  dmem_bus_if #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .stall_i(stall_i), .flush_i(flush_i),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; caller then drives inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic quiet();
    cpu_ce_i = 0; cpu_we_i = 0; cpu_sel_i = 4'h0; cpu_addr_i = 32'h0; cpu_data_i = 32'h0;
    stall_i = 0; flush_i = 0; bus_ack_i = 0; bus_data_i = 32'h0;
  endtask

  task automatic launch(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                        input logic [31:0] data);
    cpu_ce_i = 1; cpu_we_i = we; cpu_sel_i = sel; cpu_addr_i = addr; cpu_data_i = data;
  endtask

  task automatic test_reset();
    rst = 1; quiet(); cpu_ce_i = 1; bus_ack_i = 1; bus_data_i = 32'hFFFF_FFFF;
    step(); step(); settle();
    n_vec++; if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL rst_stallreq: got %b want 0", stallreq_o); end
    n_vec++; if (cpu_data_o !== 32'h0) begin n_err++; $display("FAIL rst_cpu_data: got %h want 0", cpu_data_o); end
    n_vec++; if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o} !== 4'b0) begin n_err++; $display("FAIL rst_ctrl: got %b want 0000", {bus_cyc_o, bus_stb_o, bus_we_o, bus_err_o}); end
    n_vec++; if ({bus_sel_o, bus_addr_o, bus_data_o} !== 68'h0) begin n_err++; $display("FAIL rst_fields: got %h want 0", {bus_sel_o, bus_addr_o, bus_data_o}); end
    rst = 0; quiet();
  endtask

  task automatic test_load();
    step(); launch(0, 4'b1111, 32'h0000_0104, 32'h0); settle();
    n_vec++; if (stallreq_o !== 1'b1) begin n_err++; $display("FAIL load_req_stall: got %b want 1", stallreq_o); end
    n_vec++; if (bus_cyc_o !== 1'b0) begin n_err++; $display("FAIL load_req_cyc: got %b want 0", bus_cyc_o); end
    step(); quiet(); settle();
    n_vec++; if ({bus_cyc_o, bus_stb_o, bus_we_o} !== 3'b110) begin n_err++; $display("FAIL load_busy_ctrl: got %b want 110", {bus_cyc_o, bus_stb_o, bus_we_o}); end
    n_vec++; if (bus_addr_o !== 32'h0000_0104) begin n_err++; $display("FAIL load_addr: got %h want 00000104", bus_addr_o); end
    n_vec++; if (bus_sel_o !== 4'b1111) begin n_err++; $display("FAIL load_sel: got %b want 1111", bus_sel_o); end
    n_vec++; if (stallreq_o !== 1'b1) begin n_err++; $display("FAIL load_busy_stall: got %b want 1", stallreq_o); end
    step(); bus_ack_i = 1; bus_data_i = 32'h1234_5678; settle();
    n_vec++; if (cpu_data_o !== 32'h1234_5678) begin n_err++; $display("FAIL load_data: got %h want 12345678", cpu_data_o); end
    n_vec++; if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL load_ack_stall: got %b want 0", stallreq_o); end
    step(); quiet(); settle();
    n_vec++; if ({bus_cyc_o, bus_stb_o} !== 2'b00) begin n_err++; $display("FAIL load_done_cyc: got %b want 00", {bus_cyc_o, bus_stb_o}); end
    n_vec++; if (cpu_data_o !== 32'h0) begin n_err++; $display("FAIL load_idle_data: got %h want 0", cpu_data_o); end
  endtask

  task automatic test_store();
    step(); launch(1, 4'b0100, 32'h0000_0200, 32'hABAB_ABAB); settle();
    n_vec++; if (stallreq_o !== 1'b1) begin n_err++; $display("FAIL st_req_stall: got %b want 1", stallreq_o); end
    step(); quiet(); bus_ack_i = 1; bus_data_i = 32'hDEAD_BEEF; settle();
    n_vec++; if ({bus_cyc_o, bus_we_o} !== 2'b11) begin n_err++; $display("FAIL st_cyc_we: got %b want 11", {bus_cyc_o, bus_we_o}); end
    n_vec++; if (bus_sel_o !== 4'b0100) begin n_err++; $display("FAIL st_sel: got %b want 0100", bus_sel_o); end
    n_vec++; if (bus_data_o !== 32'hABAB_ABAB) begin n_err++; $display("FAIL st_data: got %h want ababab ab", bus_data_o); end
    n_vec++; if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL st_ack_stall: got %b want 0", stallreq_o); end
    n_vec++; if (cpu_data_o !== 32'h0) begin n_err++; $display("FAIL st_cpu_data: got %h want 0", cpu_data_o); end
    step(); quiet(); settle();
    n_vec++; if ({bus_cyc_o, bus_we_o} !== 2'b00) begin n_err++; $display("FAIL st_done: got %b want 00", {bus_cyc_o, bus_we_o}); end
    n_vec++; if (bus_data_o !== 32'h0) begin n_err++; $display("FAIL st_data_clr: got %h want 0", bus_data_o); end
  endtask

  task automatic test_back_to_back();
    step(); launch(0, 4'b1111, 32'h0000_0010, 32'h0);
    step(); bus_ack_i = 1; bus_data_i = 32'h1111_1111; cpu_addr_i = 32'h0000_0020; settle();
    n_vec++; if (cpu_data_o !== 32'h1111_1111) begin n_err++; $display("FAIL b2b_first: got %h want 11111111", cpu_data_o); end
    step(); bus_ack_i = 0; settle();
    n_vec++; if ({bus_cyc_o, stallreq_o} !== 2'b01) begin n_err++; $display("FAIL b2b_relaunch: got %b want 01", {bus_cyc_o, stallreq_o}); end
    step(); quiet(); settle();
    n_vec++; if ({bus_cyc_o, bus_addr_o} !== {1'b1, 32'h0000_0020}) begin n_err++; $display("FAIL b2b_second: got %b %h want 1 00000020", bus_cyc_o, bus_addr_o); end
    bus_ack_i = 1; bus_data_i = 32'h2222_2222; settle();
    n_vec++; if (cpu_data_o !== 32'h2222_2222) begin n_err++; $display("FAIL b2b_second_data: got %h want 22222222", cpu_data_o); end
    step(); quiet();
  endtask

  task automatic test_hold();
    step(); launch(0, 4'b1111, 32'h0000_0300, 32'h0);
    step(); quiet(); bus_ack_i = 1; stall_i = 1; bus_data_i = 32'hCAFE_F00D; settle();
    n_vec++; if (cpu_data_o !== 32'hCAFE_F00D) begin n_err++; $display("FAIL hold_ack_data: got %h want cafef00d", cpu_data_o); end
    for (int i = 0; i < 3; i++) begin
      step(); bus_ack_i = (i == 1); bus_data_i = 32'h5555_0000 + i; settle();
      n_vec++; if (cpu_data_o !== 32'hCAFE_F00D) begin n_err++; $display("FAIL hold_data[%0d]: got %h want cafef00d", i, cpu_data_o); end
      n_vec++; if ({stallreq_o, bus_cyc_o} !== 2'b00) begin n_err++; $display("FAIL hold_quiet[%0d]: got %b want 00", i, {stallreq_o, bus_cyc_o}); end
    end
    stall_i = 0; bus_ack_i = 0; settle();
    step(); settle();
    n_vec++; if (cpu_data_o !== 32'h0) begin n_err++; $display("FAIL hold_exit: got %h want 0", cpu_data_o); end
    quiet();
  endtask

  task automatic test_timeout();
    step(); launch(0, 4'b0011, 32'h0000_0400, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(); quiet(); settle();
      n_vec++; if (bus_cyc_o !== 1'b1) begin n_err++; $display("FAIL tmo_cyc[%0d]: got %b want 1", i, bus_cyc_o); end
      n_vec++; if (stallreq_o !== (i < 3)) begin n_err++; $display("FAIL tmo_stall[%0d]: got %b want %b", i, stallreq_o, (i < 3)); end
    end
    step(); settle();
    n_vec++; if ({bus_cyc_o, bus_stb_o, bus_err_o} !== 3'b001) begin n_err++; $display("FAIL tmo_abort: got %b want 001", {bus_cyc_o, bus_stb_o, bus_err_o}); end
    n_vec++; if ({stallreq_o, cpu_data_o} !== 33'h0) begin n_err++; $display("FAIL tmo_cpu: got %b %h want 0 0", stallreq_o, cpu_data_o); end
    step(); settle();
    n_vec++; if (bus_err_o !== 1'b0) begin n_err++; $display("FAIL tmo_pulse: got %b want 0", bus_err_o); end
  endtask

  task automatic test_ack_on_timeout();
    step(); launch(0, 4'b1111, 32'h0000_0500, 32'h0);
    for (int i = 0; i < 3; i++) begin step(); quiet(); end
    step(); bus_ack_i = 1; bus_data_i = 32'h5A5A_5A5A; settle();
    n_vec++; if ({stallreq_o, cpu_data_o} !== {1'b0, 32'h5A5A_5A5A}) begin n_err++; $display("FAIL ackto_data: got %b %h want 0 5a5a5a5a", stallreq_o, cpu_data_o); end
    step(); quiet(); settle();
    n_vec++; if ({bus_cyc_o, bus_err_o} !== 2'b00) begin n_err++; $display("FAIL ackto_noerr: got %b want 00", {bus_cyc_o, bus_err_o}); end
  endtask

  task automatic test_flush();
    step(); launch(0, 4'b1111, 32'h0000_0600, 32'h0);
    step(); quiet(); bus_ack_i = 1; flush_i = 1; bus_data_i = 32'h7777_7777; settle();
    n_vec++; if ({stallreq_o, cpu_data_o} !== 33'h0) begin n_err++; $display("FAIL flush_busy: got %b %h want 0 0", stallreq_o, cpu_data_o); end
    step(); quiet(); bus_ack_i = 1; bus_data_i = 32'h8888_8888; settle();
    n_vec++; if ({bus_cyc_o, bus_err_o, cpu_data_o} !== 34'h0) begin n_err++; $display("FAIL flush_idle: got %b %b %h want 0 0 0", bus_cyc_o, bus_err_o, cpu_data_o); end
    bus_ack_i = 0; cpu_ce_i = 1; flush_i = 1; settle();
    n_vec++; if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL flush_noreq_stall: got %b want 0", stallreq_o); end
    step(); quiet(); settle();
    n_vec++; if (bus_cyc_o !== 1'b0) begin n_err++; $display("FAIL flush_noreq_cyc: got %b want 0", bus_cyc_o); end
  endtask

  task automatic test_rst_mid();
    step(); launch(1, 4'b0011, 32'h0000_0700, 32'h0000_0099);
    step(); quiet(); settle();
    n_vec++; if (bus_cyc_o !== 1'b1) begin n_err++; $display("FAIL rstm_busy: got %b want 1", bus_cyc_o); end
    rst = 1; settle();
    n_vec++; if ({stallreq_o, cpu_data_o} !== 33'h0) begin n_err++; $display("FAIL rstm_comb: got %b %h want 0 0", stallreq_o, cpu_data_o); end
    step(); rst = 0; bus_ack_i = 1; bus_data_i = 32'h0000_0012; settle();
    n_vec++; if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o} !== 71'h0) begin n_err++; $display("FAIL rstm_bus: got %h want 0", {bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o}); end
    n_vec++; if ({stallreq_o, cpu_data_o} !== 33'h0) begin n_err++; $display("FAIL rstm_ack_ignored: got %b %h want 0 0", stallreq_o, cpu_data_o); end
    step(); quiet(); settle();
    n_vec++; if ({bus_cyc_o, bus_err_o} !== 2'b00) begin n_err++; $display("FAIL rstm_after: got %b want 00", {bus_cyc_o, bus_err_o}); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_hold();
    test_timeout();
    test_ack_on_timeout();
    test_flush();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
